// File: rtl/param_reg_bank.sv
// Per-core register bank with one-hot bus access, local inc/clear,
// registered reads and a registered loop-compare flag.
module param_reg_bank #(
  parameter int unsigned REG_COUNT   = 11,
  parameter int unsigned REG_WIDTH   = 12,
  parameter int unsigned CORE_NUMBER = 0,
  parameter int unsigned CORE_IDX    = 10,
  parameter int unsigned CMP_A       = 4,
  parameter int unsigned CMP_B       = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [REG_COUNT-1:0] write_en,
  input  logic [REG_COUNT-1:0] read_en,
  input  logic [REG_COUNT-1:0] inc_en,
  input  logic [REG_COUNT-1:0] clr_en,
  input  logic [REG_WIDTH-1:0] datain,
  output logic [REG_WIDTH-1:0] dataout,
  output logic                 rd_valid,
  output logic                 wr_conflict,
  output logic                 rd_conflict,
  output logic [REG_COUNT-1:0] inc_wrap,
  output logic                 cmp_eq
);

  localparam logic [REG_WIDTH-1:0] CORE_RST =
    REG_WIDTH'(CORE_NUMBER);
  localparam logic [REG_WIDTH-1:0] A_RST =
    (CMP_A == CORE_IDX) ? CORE_RST : '0;
  localparam logic [REG_WIDTH-1:0] B_RST =
    (CMP_B == CORE_IDX) ? CORE_RST : '0;
  localparam logic CMP_RST = (A_RST == B_RST);

  logic [REG_WIDTH-1:0] regs_q [REG_COUNT];
  logic [REG_WIDTH-1:0] regs_d [REG_COUNT];

  logic [REG_WIDTH-1:0] dout_q, dout_d;
  logic                 vld_q, vld_d;
  logic                 wrc_q, wrc_d;
  logic                 rdc_q, rdc_d;
  logic [REG_COUNT-1:0] wrap_q, wrap_d;
  logic                 cmp_q, cmp_d;

  logic [REG_COUNT-1:0] wr_sel;
  logic                 rd_one;
  logic [REG_WIDTH-1:0] rd_data;

  always_comb begin
    // Isolate the lowest set write bit so a multi-hot write hits one reg.
    wr_sel = write_en & (~write_en + REG_COUNT'(1));
    wrc_d  = |(write_en & (write_en - REG_COUNT'(1)));
    rdc_d  = |(read_en & (read_en - REG_COUNT'(1)));
    rd_one = (|read_en) && !rdc_d;
    rd_data = '0;
    wrap_d  = '0;
    for (int i = 0; i < REG_COUNT; i++) begin
      regs_d[i] = regs_q[i];
      if (read_en[i]) rd_data = rd_data | regs_q[i];
      if (clr_en[i]) begin
        regs_d[i] = '0;
      end else if (wr_sel[i]) begin
        regs_d[i] = datain;
      end else if (inc_en[i]) begin
        regs_d[i] = regs_q[i] + REG_WIDTH'(1);
        wrap_d[i] = &regs_q[i];
      end
    end
    dout_d = rd_one ? rd_data : dout_q;
    vld_d  = rd_one;
    cmp_d  = (regs_d[CMP_A] == regs_d[CMP_B]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= (i == CORE_IDX) ? CORE_RST : '0;
      end
      dout_q <= '0;
      vld_q  <= 1'b0;
      wrc_q  <= 1'b0;
      rdc_q  <= 1'b0;
      wrap_q <= '0;
      cmp_q  <= CMP_RST;
    end else begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= regs_d[i];
      end
      dout_q <= dout_d;
      vld_q  <= vld_d;
      wrc_q  <= wrc_d;
      rdc_q  <= rdc_d;
      wrap_q <= wrap_d;
      cmp_q  <= cmp_d;
    end
  end

  assign dataout     = dout_q;
  assign rd_valid    = vld_q;
  assign wr_conflict = wrc_q;
  assign rd_conflict = rdc_q;
  assign inc_wrap    = wrap_q;
  assign cmp_eq      = cmp_q;

endmodule

// File: tb/tb_param_reg_bank.sv
// Scoreboard bench for param_reg_bank: directed scenarios then
// random traffic against an array-based reference model.
module tb_param_reg_bank;

  localparam int N = 11;
  localparam int W = 12;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] write_en, read_en, inc_en, clr_en;
  logic [W-1:0] datain;
  logic [W-1:0] dataout;
  logic         rd_valid, wr_conflict, rd_conflict, cmp_eq;
  logic [N-1:0] inc_wrap;

  param_reg_bank #(
    .REG_COUNT(N), .REG_WIDTH(W), .CORE_NUMBER(3),
    .CORE_IDX(10), .CMP_A(4), .CMP_B(1)
  ) dut (
    .clk(clk), .reset(reset),
    .write_en(write_en), .read_en(read_en),
    .inc_en(inc_en), .clr_en(clr_en),
    .datain(datain), .dataout(dataout),
    .rd_valid(rd_valid), .wr_conflict(wr_conflict),
    .rd_conflict(rd_conflict), .inc_wrap(inc_wrap),
    .cmp_eq(cmp_eq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    logic         v;
    logic         wc;
    logic         rc;
    logic [N-1:0] w;
    logic         c;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  int   m [N];
  int   mdout = 0;

  task automatic check(string nm, logic [31:0] a, logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  // Reference: apply the priority rules directly on an int array.
  task automatic drv(input logic [N-1:0] we, input logic [N-1:0] re,
                     input logic [N-1:0] ie, input logic [N-1:0] ce,
                     input int din, input bit rst);
    exp_t e;
    int   nv [N];
    int   ws;
    @(negedge clk);
    write_en = we; read_en = re; inc_en = ie; clr_en = ce;
    datain = W'(din); reset = rst;
    e.w = '0;
    if (rst) begin
      foreach (m[i]) m[i] = (i == 10) ? 3 : 0;
      mdout = 0;
      e.v = 0; e.wc = 0; e.rc = 0;
    end else begin
      ws = -1;
      for (int i = 0; i < N; i++) if (we[i] && ws < 0) ws = i;
      for (int i = 0; i < N; i++) begin
        if (ce[i]) nv[i] = 0;
        else if (i == ws) nv[i] = din % 4096;
        else if (ie[i]) begin
          nv[i] = (m[i] + 1) % 4096;
          e.w[i] = (m[i] == 4095);
        end else nv[i] = m[i];
      end
      e.v  = ($countones(re) == 1);
      e.rc = ($countones(re) > 1);
      e.wc = ($countones(we) > 1);
      if (e.v) begin
        for (int i = 0; i < N; i++) if (re[i]) mdout = m[i];
      end
      foreach (m[i]) m[i] = nv[i];
    end
    e.d = W'(mdout);
    e.c = (m[4] == m[1]);
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("dataout", 32'(dataout), 32'(e.d));
        check("rd_valid", 32'(rd_valid), 32'(e.v));
        check("wr_conflict", 32'(wr_conflict), 32'(e.wc));
        check("rd_conflict", 32'(rd_conflict), 32'(e.rc));
        check("inc_wrap", 32'(inc_wrap), 32'(e.w));
        check("cmp_eq", 32'(cmp_eq), 32'(e.c));
      end
    end
  end

  function automatic logic [N-1:0] pick_sel();
    case ($urandom_range(0, 3))
      0:       return '0;
      3:       return N'($urandom);
      default: return N'(1) << $urandom_range(0, N - 1);
    endcase
  endfunction

  function automatic int pick_data();
    case ($urandom_range(0, 3))
      0:       return 'hFFF;
      1:       return 'hFFE;
      default: return int'($urandom_range(0, 4095));
    endcase
  endfunction

  initial begin : stim
    int budget;
    reset = 1'b1; write_en = '0; read_en = '0;
    inc_en = '0; clr_en = '0; datain = '0;
    drv('0, '0, '0, '0, 0, 1);
    drv('0, '0, '0, '0, 0, 1);
    for (int i = 0; i < N; i++) drv('0, N'(1) << i, '0, '0, 0, 0);
    drv(11'h004, '0, '0, '0, 'hABC, 0);
    drv('0, 11'h004, '0, '0, 0, 0);
    drv(11'h004, 11'h004, '0, '0, 'h123, 0);
    drv('0, 11'h004, '0, '0, 0, 0);
    drv(11'h00A, '0, '0, '0, 'h055, 0);
    drv('0, 11'h002, '0, '0, 0, 0);
    drv('0, 11'h008, '0, '0, 0, 0);
    drv(11'h010, '0, '0, '0, 'hFFE, 0);
    drv('0, '0, 11'h010, '0, 0, 0);
    drv('0, 11'h010, 11'h010, '0, 0, 0);
    drv('0, 11'h010, '0, '0, 0, 0);
    drv('0, '0, 11'h010, 11'h010, 0, 0);
    drv(11'h002, '0, '0, '0, 5, 0);
    for (int k = 0; k < 6; k++) drv('0, '0, 11'h010, '0, 0, 0);
    drv('0, 11'h006, '0, '0, 0, 0);
    drv(11'h001, '0, 11'h7F0, '0, 'h777, 0);
    drv(11'h004, 11'h004, 11'h7FF, '0, 'h111, 1);
    for (int i = 0; i < N; i++) drv('0, N'(1) << i, '0, '0, 0, 0);
    for (int k = 0; k < 3000; k++) begin
      drv(pick_sel(), pick_sel(),
          N'($urandom & $urandom),
          N'($urandom & $urandom & $urandom),
          pick_data(), $urandom_range(0, 99) == 0);
    end
    @(negedge clk);
    write_en = '0; read_en = '0; inc_en = '0; clr_en = '0;
    budget = 0;
    while (q.size() > 0 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
